// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the local-port arbiter: transfer codes,
// the size encoder, the owner-index width helper and the data-phase record.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Owner field is sized for the largest legal requester count (8).
    localparam int OWNER_W = 3;

    function automatic logic [2:0] hsize_enc(input int unsigned bytes);
        case (bytes)
            1:       return 3'b000;
            2:       return 3'b001;
            4:       return 3'b010;
            8:       return 3'b011;
            16:      return 3'b100;
            default: return 3'b010;
        endcase
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
        logic               write;
    } dp_info_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin find-first: first asserted request scanning upward from ptr,
// wrapping at NUM_REQ-1. Returns index 0 and an all-zero one-hot when idle.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i >= NUM_REQ) ? IDX_W'(int'(ptr) + i - NUM_REQ)
                                              : IDX_W'(int'(ptr) + i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        onehot = found ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/ahb_local_arbiter.sv
// Shares the AHB-Lite master's local port between NUM_REQ requesters with
// round-robin arbitration, bounded lock retention and read-return routing.
module ahb_local_arbiter
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2,
    parameter int MAX_HOLD   = 4,
    parameter int IDX_W      = idx_w(NUM_REQ)
) (
    input  logic                           hclk_i,
    input  logic                           hrst_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0]             wr_i,
    input  logic [NUM_REQ-1:0]             lock_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [NUM_REQ-1:0]             rvalid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           m_req_o,
    output logic                           m_wr_o,
    output logic [ADDR_WIDTH-1:0]          m_addr_o,
    output logic [DATA_WIDTH-1:0]          m_wdata_o,
    input  logic                           m_ready_i,
    input  logic [DATA_WIDTH-1:0]          m_rdata_i,
    input  logic                           m_rvalid_i,
    output logic [IDX_W-1:0]               owner_o
);

    // Handshake: a requester raises req_i with wr/addr/wdata and holds them
    // stable until gnt_o pulses; gnt_o is the same-cycle accept (req & ready),
    // so a beat is transferred exactly in the cycle its gnt_o bit is high.

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   last_win;
    logic [HOLD_W-1:0]  hold_cnt;
    dp_info_t           dp;

    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   next_idx;
    logic               accept;
    logic               keep_hold;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req_i),
        .ptr    (rr_ptr),
        .onehot (win_oh),
        .idx    (win_idx)
    );

    assign m_req_o   = |req_i;
    assign m_wr_o    = wr_i[win_idx];
    assign m_addr_o  = addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_wdata_o = wdata_i[win_idx*DATA_WIDTH +: DATA_WIDTH];

    assign accept = m_req_o & m_ready_i;
    assign gnt_o  = win_oh & {NUM_REQ{accept}};

    assign next_idx  = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign keep_hold = lock_i[win_idx] && (win_idx == last_win) &&
                       (hold_cnt < HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge hclk_i) begin
        if (hrst_i) begin
            rr_ptr   <= '0;
            last_win <= '0;
            hold_cnt <= '0;
            dp       <= '0;
        end else begin
            if (accept) begin
                last_win <= win_idx;
                if (keep_hold) begin
                    rr_ptr   <= win_idx;
                    hold_cnt <= hold_cnt + 1'b1;
                end else if (lock_i[win_idx] && (win_idx != last_win)) begin
                    rr_ptr   <= win_idx;
                    hold_cnt <= '0;
                end else begin
                    // Unlocked, or the lock just used up its hold budget.
                    rr_ptr   <= next_idx;
                    hold_cnt <= '0;
                end
                dp.valid <= 1'b1;
                dp.owner <= OWNER_W'(win_idx);
                dp.write <= m_wr_o;
            end else if (m_ready_i) begin
                dp.valid <= 1'b0;
            end
        end
    end

    // Completion belongs to the beat already in its data phase (old owner).
    assign rvalid_o = (NUM_REQ'(1) << dp.owner) &
                      {NUM_REQ{m_rvalid_i & dp.valid & ~dp.write}};
    assign rdata_o  = m_rdata_i;
    assign owner_o  = dp.owner[IDX_W-1:0];

endmodule

// File: tb/tb_ahb_local_arbiter.sv
// Self-checking bench for ahb_local_arbiter: directed vector table, hand-written
// lock/reset sequences, and randomized traffic against a rule-level model.
module tb_ahb_local_arbiter;

    localparam int N        = 2;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 4;
    localparam int IW       = 1;

    logic              hclk_i = 1'b0;
    logic              hrst_i;
    logic [N-1:0]      req_i, wr_i, lock_i;
    logic [N*AW-1:0]   addr_i;
    logic [N*DW-1:0]   wdata_i;
    logic [N-1:0]      gnt_o, rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic              m_req_o, m_wr_o;
    logic [AW-1:0]     m_addr_o;
    logic [DW-1:0]     m_wdata_o;
    logic              m_ready_i;
    logic [DW-1:0]     m_rdata_i;
    logic              m_rvalid_i;
    logic [IW-1:0]     owner_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [N-1:0] exp_q[$];

    ahb_local_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REQ    (N),
        .MAX_HOLD   (MAX_HOLD)
    ) dut (
        .hclk_i     (hclk_i),
        .hrst_i     (hrst_i),
        .req_i      (req_i),
        .wr_i       (wr_i),
        .lock_i     (lock_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .m_req_o    (m_req_o),
        .m_wr_o     (m_wr_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_ready_i  (m_ready_i),
        .m_rdata_i  (m_rdata_i),
        .m_rvalid_i (m_rvalid_i),
        .owner_o    (owner_o)
    );

    // Clock / reset
    always #5 hclk_i = ~hclk_i;

    task automatic idle_inputs();
        req_i      = '0;
        wr_i       = '0;
        lock_i     = '0;
        m_ready_i  = 1'b1;
        m_rvalid_i = 1'b0;
        m_rdata_i  = '0;
    endtask

    task automatic do_reset();
        hrst_i = 1'b1;
        idle_inputs();
        repeat (2) @(posedge hclk_i);
        #1 hrst_i = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge hclk_i);
        #1;
    endtask

    // Directed vector table
    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  wr;
        logic          ready;
        logic          mrv;
        logic [DW-1:0] rdata;
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_rv;
        logic [AW-1:0] e_addr;
        logic          e_wr;
        logic [DW-1:0] e_wdata;
        logic [IW-1:0] e_owner;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic [N-1:0] req, input logic [N-1:0] wr,
                                input logic ready, input logic mrv, input logic [DW-1:0] rdata,
                                input logic [N-1:0] e_gnt, input logic [N-1:0] e_rv,
                                input logic [AW-1:0] e_addr, input logic e_wr,
                                input logic [DW-1:0] e_wdata, input logic [IW-1:0] e_owner);
        vec_t v;
        v.req = req; v.wr = wr; v.ready = ready; v.mrv = mrv; v.rdata = rdata;
        v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_addr = e_addr; v.e_wr = e_wr;
        v.e_wdata = e_wdata; v.e_owner = e_owner;
        return v;
    endfunction

    // Reference model state (integers, rule level)
    int   m_ptr, m_last, m_streak, m_dpo;
    bit   m_dpv, m_dpw;

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int model_winner(input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (bit_at(r, (m_ptr + k) % N)) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_last = 0; m_streak = 0; m_dpo = 0; m_dpv = 0; m_dpw = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] w,
                              input logic [N-1:0] l, input logic rdy);
        int win;
        bit lk;
        win = model_winner(r);
        if (win >= 0 && rdy) begin
            lk = bit_at(l, win);
            if (lk && win == m_last && m_streak < MAX_HOLD - 1) begin
                m_ptr = win; m_streak++;
            end else if (lk && win != m_last) begin
                m_ptr = win; m_streak = 0;
            end else begin
                m_ptr = (win + 1) % N; m_streak = 0;
            end
            m_last = win;
            m_dpv = 1; m_dpo = win; m_dpw = bit_at(w, win);
        end else if (rdy) begin
            m_dpv = 0;
        end
    endtask

    logic [N-1:0] lock_seq[6];
    logic [N-1:0] last_gnt;

    initial begin
        addr_i  = {32'h0000_0200, 32'h0000_0100};
        wdata_i = {32'h0000_0055, 32'h0000_00AA};
        do_reset();

        // Reset state
        @(negedge hclk_i);
        check("reset_gnt", gnt_o, 0);
        check("reset_rvalid", rvalid_o, 0);
        check("reset_owner", owner_o, 0);
        next_cycle();

        tbl[0]  = mk(2'b01, 2'b00, 1, 0, 32'h0,    2'b01, 2'b00, 32'h100, 0, 32'hAA, 0);
        tbl[1]  = mk(2'b00, 2'b00, 1, 1, 32'hDEAD, 2'b00, 2'b01, 32'h100, 0, 32'hAA, 0);
        tbl[2]  = mk(2'b11, 2'b00, 1, 0, 32'h0,    2'b10, 2'b00, 32'h200, 0, 32'h55, 0);
        tbl[3]  = mk(2'b11, 2'b00, 1, 1, 32'h1111, 2'b01, 2'b10, 32'h100, 0, 32'hAA, 1);
        tbl[4]  = mk(2'b11, 2'b00, 1, 1, 32'h2222, 2'b10, 2'b01, 32'h200, 0, 32'h55, 0);
        tbl[5]  = mk(2'b11, 2'b00, 1, 1, 32'h3333, 2'b01, 2'b10, 32'h100, 0, 32'hAA, 1);
        tbl[6]  = mk(2'b10, 2'b00, 0, 0, 32'h0,    2'b00, 2'b00, 32'h200, 0, 32'h55, 0);
        tbl[7]  = tbl[6];
        tbl[8]  = tbl[6];
        tbl[9]  = mk(2'b10, 2'b00, 1, 1, 32'hBEEF, 2'b10, 2'b01, 32'h200, 0, 32'h55, 0);
        tbl[10] = mk(2'b10, 2'b10, 1, 1, 32'h4444, 2'b10, 2'b10, 32'h200, 1, 32'h55, 1);
        tbl[11] = mk(2'b00, 2'b00, 1, 1, 32'h5555, 2'b00, 2'b00, 32'h100, 0, 32'hAA, 1);
        tbl[12] = mk(2'b00, 2'b00, 1, 1, 32'h6666, 2'b00, 2'b00, 32'h100, 0, 32'hAA, 1);

        for (int i = 0; i < 13; i++) begin
            req_i = tbl[i].req; wr_i = tbl[i].wr; lock_i = '0;
            m_ready_i = tbl[i].ready; m_rvalid_i = tbl[i].mrv; m_rdata_i = tbl[i].rdata;
            @(negedge hclk_i);
            check($sformatf("vec%0d_gnt", i), gnt_o, tbl[i].e_gnt);
            check($sformatf("vec%0d_rvalid", i), rvalid_o, tbl[i].e_rv);
            check($sformatf("vec%0d_rdata", i), rdata_o, tbl[i].rdata);
            check($sformatf("vec%0d_mreq", i), m_req_o, |tbl[i].req);
            check($sformatf("vec%0d_maddr", i), m_addr_o, tbl[i].e_addr);
            check($sformatf("vec%0d_mwr", i), m_wr_o, tbl[i].e_wr);
            check($sformatf("vec%0d_mwdata", i), m_wdata_o, tbl[i].e_wdata);
            check($sformatf("vec%0d_owner", i), owner_o, tbl[i].e_owner);
            next_cycle();
        end

        // Lock bound: requester 0 locked, both requesting
        do_reset();
        lock_seq[0] = 2'b01; lock_seq[1] = 2'b01; lock_seq[2] = 2'b01;
        lock_seq[3] = 2'b01; lock_seq[4] = 2'b10; lock_seq[5] = 2'b01;
        req_i = 2'b11; lock_i = 2'b01; m_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge hclk_i);
            check($sformatf("lock%0d_gnt", i), gnt_o, lock_seq[i]);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // Reset mid-read
        do_reset();
        req_i = 2'b01;
        @(negedge hclk_i);
        check("rstrd_accept_gnt", gnt_o, 2'b01);
        @(posedge hclk_i);
        #1 hrst_i = 1'b1; req_i = '0;
        next_cycle();
        hrst_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'hCAFE;
        @(negedge hclk_i);
        check("rstrd_rvalid_dropped", rvalid_o, 2'b00);
        check("rstrd_owner", owner_o, 0);
        next_cycle();
        m_rvalid_i = 1'b0; req_i = 2'b11;
        @(negedge hclk_i);
        check("rstrd_first_gnt", gnt_o, 2'b01);
        next_cycle();
        idle_inputs();

        // Randomized traffic against the model
        do_reset();
        model_reset();
        exp_q.delete();
        last_gnt = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            int win;
            logic [N-1:0] e_gnt, e_rv;
            for (int k = 0; k < N; k++) begin
                if (!bit_at(req_i, k) || bit_at(last_gnt, k)) begin
                    logic nr, nw;
                    nr = (cyc < 790) && ($urandom_range(0, 1) == 1);
                    nw = ($urandom_range(0, 2) == 0);
                    req_i   = (req_i & ~(N'(1) << k)) | (N'(nr) << k);
                    wr_i    = (wr_i & ~(N'(1) << k)) | (N'(nw) << k);
                    addr_i  = (addr_i & ~((N*AW)'({AW{1'b1}}) << (k*AW))) |
                              ((N*AW)'($urandom) << (k*AW));
                    wdata_i = (wdata_i & ~((N*DW)'({DW{1'b1}}) << (k*DW))) |
                              ((N*DW)'($urandom) << (k*DW));
                end
            end
            lock_i     = N'($urandom_range(0, (1 << N) - 1));
            m_ready_i  = (cyc >= 790) || ($urandom_range(0, 3) != 0);
            m_rvalid_i = m_dpv ? (!m_dpw && m_ready_i) : ($urandom_range(0, 9) == 0);
            m_rdata_i  = $urandom;

            @(negedge hclk_i);
            win   = model_winner(req_i);
            e_gnt = (win >= 0 && m_ready_i) ? (N'(1) << win) : '0;
            e_rv  = (m_rvalid_i && m_dpv && !m_dpw) ? (N'(1) << m_dpo) : '0;
            check("rnd_gnt", gnt_o, e_gnt);
            check("rnd_rvalid", rvalid_o, e_rv);
            check("rnd_owner", owner_o, m_dpo);
            check("rnd_mreq", m_req_o, win >= 0);
            if (win >= 0) begin
                check("rnd_maddr", m_addr_o, AW'(addr_i >> (win*AW)));
                check("rnd_mwr", m_wr_o, bit_at(wr_i, win));
                check("rnd_mwdata", m_wdata_o, DW'(wdata_i >> (win*DW)));
            end
            // Scoreboard: every accepted read owes exactly one routed return
            if (rvalid_o != '0) begin
                if (exp_q.size() == 0) check("sb_unexpected_rvalid", rvalid_o, 0);
                else check("sb_rvalid_owner", rvalid_o, exp_q.pop_front());
                check("sb_rdata", rdata_o, m_rdata_i);
            end
            if (gnt_o != '0 && !m_wr_o) exp_q.push_back(gnt_o);
            last_gnt = e_gnt;

            @(posedge hclk_i);
            model_step(req_i, wr_i, lock_i, m_ready_i);
            #1;
        end
        check("sb_queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
